// File: rtl/inst_sram_ctrl_if.sv
// rtl/inst_sram_ctrl_if.sv - fetch port between the cpu core and the instruction SRAM controller
//
// Purpose: groups the core's fetch request/response signals.
// Signals:
//   instAddr_i    byte fetch address (core -> controller)
//   instEnable_i  fetch request      (core -> controller)
//   instData_o    instruction word   (controller -> core)
//   stall_o       hold PC and IF/ID  (controller -> core)
// Modports: master = core side, slave = controller side.
interface inst_sram_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] instAddr_i;
    logic              instEnable_i;
    logic [DATA_W-1:0] instData_o;
    logic              stall_o;

    modport master (
        output instAddr_i,
        output instEnable_i,
        input  instData_o,
        input  stall_o
    );

    modport slave (
        input  instAddr_i,
        input  instEnable_i,
        output instData_o,
        output stall_o
    );
endinterface

// File: rtl/inst_sram_ctrl.sv
// rtl/inst_sram_ctrl.sv - instruction fetch controller with fetch buffer in front of an async SRAM
//
// Purpose: serves core fetches from a multi-cycle asynchronous SRAM. A one-entry
// fetch buffer answers repeated fetches of the same address without waiting; a
// miss stalls the core for WAIT_CYCLES+2 cycles while the word is read.
// Optional macro INST_PREFETCH_EN adds a second entry filled speculatively with
// the next sequential word after each demand fill.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   fetch (slave)     instAddr_i, instEnable_i in; instData_o, stall_o out
//   sram_addr_o       SRAM word address (latched request address bits [SRAM_AW+1:2])
//   sram_rdata_i      SRAM read data
//   sram_ce_n_o       chip enable, active-low
//   sram_oe_n_o       output enable, active-low
//   sram_we_n_o       write enable, tied inactive (read-only port)
module inst_sram_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    inst_sram_ctrl_if.slave    fetch,
    output logic [SRAM_AW-1:0] sram_addr_o,
    input  logic [DATA_W-1:0]  sram_rdata_i,
    output logic               sram_ce_n_o,
    output logic               sram_oe_n_o,
    output logic               sram_we_n_o
);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic {IDLE, READ} state_t;

    state_t            state, stateNext;
    logic [ADDR_W-1:0] reqAddr, reqAddrNext;
    logic [3:0]        cnt, cntNext;
    logic              strobeN, strobeNNext;
    logic              bufValid, bufValidNext;
    logic [ADDR_W-1:0] bufAddr, bufAddrNext;
    logic [DATA_W-1:0] bufData, bufDataNext;
    logic              stallC;
    logic [DATA_W-1:0] dataC;

    logic              reqEn;
    logic [ADDR_W-1:0] addr;
    logic              hitBuf, hitPf, missNow;

    assign reqEn   = fetch.instEnable_i;
    assign addr    = fetch.instAddr_i;
    assign hitBuf  = bufValid && (addr == bufAddr);
    assign missNow = reqEn && !hitBuf && !hitPf;

`ifdef INST_PREFETCH_EN
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    logic              pfValid, pfValidNext;
    logic [ADDR_W-1:0] pfAddr, pfAddrNext;
    logic [DATA_W-1:0] pfData, pfDataNext;
    logic              isPf, isPfNext;           // current READ is speculative
    logic              pfPending, pfPendingNext; // a prefetch should start at next idle slot
    logic [ADDR_W-1:0] pfTarget, pfTargetNext;

    assign hitPf = pfValid && (addr == pfAddr);
`else
    assign hitPf = 1'b0;
`endif

    always_comb begin
        stateNext    = state;
        reqAddrNext  = reqAddr;
        cntNext      = cnt;
        strobeNNext  = strobeN;
        bufValidNext = bufValid;
        bufAddrNext  = bufAddr;
        bufDataNext  = bufData;
        stallC       = 1'b0;
        dataC        = '0;
`ifdef INST_PREFETCH_EN
        pfValidNext   = pfValid;
        pfAddrNext    = pfAddr;
        pfDataNext    = pfData;
        isPfNext      = isPf;
        pfPendingNext = pfPending;
        pfTargetNext  = pfTarget;
`endif
        case (state)
            IDLE: begin
                if (missNow) begin
                    stallC      = 1'b1;
                    reqAddrNext = addr;
                    cntNext     = WAIT_LOAD;
                    strobeNNext = 1'b0;
                    stateNext   = READ;
`ifdef INST_PREFETCH_EN
                    isPfNext      = 1'b0;
                    pfPendingNext = 1'b0;
`endif
                end else begin
`ifdef INST_PREFETCH_EN
                    if (reqEn) dataC = hitBuf ? bufData : pfData;
                    if (reqEn && !hitBuf && hitPf) begin
                        // Promote the consumed prefetch and queue the next sequential word.
                        bufValidNext  = 1'b1;
                        bufAddrNext   = pfAddr;
                        bufDataNext   = pfData;
                        pfValidNext   = 1'b0;
                        pfPendingNext = 1'b1;
                        pfTargetNext  = pfAddr + WORD_STEP;
                    end else if (pfPending) begin
                        reqAddrNext   = pfTarget;
                        cntNext       = WAIT_LOAD;
                        strobeNNext   = 1'b0;
                        stateNext     = READ;
                        isPfNext      = 1'b1;
                        pfPendingNext = 1'b0;
                    end
`else
                    if (reqEn) dataC = bufData;
`endif
                end
            end

            READ: begin
`ifdef INST_PREFETCH_EN
                if (isPf) begin
                    if (reqEn && !missNow) begin
                        dataC = hitBuf ? bufData : pfData;
                    end else if (missNow && addr != reqAddr) begin
                        // Unrelated demand miss: drop the speculative read, reuse the access.
                        stallC      = 1'b1;
                        reqAddrNext = addr;
                        cntNext     = WAIT_LOAD;
                        isPfNext    = 1'b0;
                    end else if (missNow && cnt != 4'd0) begin
                        stallC = 1'b1;
                    end else if (missNow) begin
                        // Demand for the word arriving this cycle: forward it directly.
                        dataC = sram_rdata_i;
                    end

                    if (!(missNow && addr != reqAddr)) begin
                        if (cnt == 4'd0) begin
                            if (missNow) begin
                                // Word was consumed: keep it as the demand entry and
                                // stream straight on to the following word.
                                bufValidNext = 1'b1;
                                bufAddrNext  = reqAddr;
                                bufDataNext  = sram_rdata_i;
                                reqAddrNext  = reqAddr + WORD_STEP;
                                cntNext      = WAIT_LOAD;
                            end else begin
                                pfValidNext = 1'b1;
                                pfAddrNext  = reqAddr;
                                pfDataNext  = sram_rdata_i;
                                strobeNNext = 1'b1;
                                stateNext   = IDLE;
                                isPfNext    = 1'b0;
                            end
                        end else begin
                            cntNext = cnt - 4'd1;
                        end
                    end
                end else
`endif
                begin
                    stallC = 1'b1;
                    if (cnt == 4'd0) begin
                        bufValidNext = 1'b1;
                        bufAddrNext  = reqAddr;
                        bufDataNext  = sram_rdata_i;
                        strobeNNext  = 1'b1;
                        stateNext    = IDLE;
`ifdef INST_PREFETCH_EN
                        pfPendingNext = 1'b1;
                        pfTargetNext  = reqAddr + WORD_STEP;
`endif
                    end else begin
                        cntNext = cnt - 4'd1;
                    end
                end
            end

            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            reqAddr  <= '0;
            cnt      <= 4'd0;
            strobeN  <= 1'b1;
            bufValid <= 1'b0;
            bufAddr  <= '0;
            bufData  <= '0;
`ifdef INST_PREFETCH_EN
            pfValid   <= 1'b0;
            pfAddr    <= '0;
            pfData    <= '0;
            isPf      <= 1'b0;
            pfPending <= 1'b0;
            pfTarget  <= '0;
`endif
        end else begin
            state    <= stateNext;
            reqAddr  <= reqAddrNext;
            cnt      <= cntNext;
            strobeN  <= strobeNNext;
            bufValid <= bufValidNext;
            bufAddr  <= bufAddrNext;
            bufData  <= bufDataNext;
`ifdef INST_PREFETCH_EN
            pfValid   <= pfValidNext;
            pfAddr    <= pfAddrNext;
            pfData    <= pfDataNext;
            isPf      <= isPfNext;
            pfPending <= pfPendingNext;
            pfTarget  <= pfTargetNext;
`endif
        end
    end

    // Outputs are combinational; force them quiet while reset is held.
    assign fetch.stall_o    = stallC && !rst;
    assign fetch.instData_o = rst ? '0 : dataC;
    assign sram_addr_o      = reqAddr[SRAM_AW+1:2];
    assign sram_ce_n_o      = strobeN;
    assign sram_oe_n_o      = strobeN;
    assign sram_we_n_o      = 1'b1;
endmodule

// File: tb/tb_inst_sram_ctrl.sv
// tb/tb_inst_sram_ctrl.sv - self-checking bench for inst_sram_ctrl
module tb_inst_sram_ctrl;
    localparam int WAIT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_sram_ctrl_if #(.ADDR_W(32), .DATA_W(32)) fetch ();

    logic [17:0] sramAddr;
    logic [31:0] sramRdata;
    logic        ceN, oeN, weN;
    logic [31:0] mem [64];

    assign sramRdata = (!ceN && !oeN) ? mem[sramAddr[5:0]] : 32'hDEAD_DEAD;

    inst_sram_ctrl #(
        .ADDR_W(32), .DATA_W(32), .SRAM_AW(18), .WAIT_CYCLES(WAIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fetch(fetch),
        .sram_addr_o(sramAddr),
        .sram_rdata_i(sramRdata),
        .sram_ce_n_o(ceN),
        .sram_oe_n_o(oeN),
        .sram_we_n_o(weN)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: one buffered word plus the number of SRAM cycles still owed.
    logic        mValid;
    logic [31:0] mAddr, mData, mPend;
    int          mBusy;
    logic        sStall, sCeN;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mValid = 1'b0;
        mAddr  = '0;
        mData  = '0;
        mPend  = '0;
        mBusy  = 0;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
    task automatic step(input logic en, input logic [31:0] a);
        logic        eStall, eCeN, hit;
        logic [31:0] eData;
        fetch.instEnable_i = en;
        fetch.instAddr_i   = a;
        @(negedge clk);
        hit = en && mValid && (a == mAddr);
        if (mBusy > 0) begin
            eStall = 1'b1; eData = '0; eCeN = 1'b0;
        end else if (hit) begin
            eStall = 1'b0; eData = mData; eCeN = 1'b1;
        end else begin
            eStall = en; eData = '0; eCeN = 1'b1;
        end
        chk("stall", {31'd0, fetch.stall_o}, {31'd0, eStall});
        chk("data", fetch.instData_o, eData);
        chk("ce_n", {31'd0, ceN}, {31'd0, eCeN});
        chk("oe_n", {31'd0, oeN}, {31'd0, eCeN});
        chk("we_n", {31'd0, weN}, 32'd1);
        if (mBusy > 0) chk("sram_addr", {14'd0, sramAddr}, {14'd0, mPend[19:2]});
        sStall = fetch.stall_o;
        sCeN   = ceN;
        if (mBusy > 0) begin
            mBusy--;
            if (mBusy == 0) begin
                mValid = 1'b1;
                mAddr  = mPend;
                mData  = mem[mPend[7:2]];
            end
        end else if (en && !hit) begin
            mPend = a;
            mBusy = WAIT + 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          stallCnt, ceCnt;
        logic        en;
        logic [31:0] a, prevA, savedAddr;

        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h1234_ABCD;
        modelReset();

        // Reset with a pending request: everything quiet.
        rst = 1'b1;
        fetch.instEnable_i = 1'b1;
        fetch.instAddr_i   = 32'h4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'd0, fetch.stall_o}, 32'd0);
        chk("rst_data", fetch.instData_o, 32'd0);
        chk("rst_ce_n", {31'd0, ceN}, 32'd1);
        chk("rst_oe_n", {31'd0, oeN}, 32'd1);
        chk("rst_sram_addr", {14'd0, sramAddr}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        step(1'b0, 32'h0);

        // First fetch of 0x0: exactly WAIT+2 stall cycles, then the word.
        stallCnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h0);
            if (sStall) stallCnt++;
        end
        chk("miss_stall_len", stallCnt, 32'd4);

        // Holding the same address: no stall, no SRAM access.
        stallCnt = 0;
        ceCnt    = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h0);
            if (sStall) stallCnt++;
            if (!sCeN) ceCnt++;
        end
        chk("hold_stall", stallCnt, 32'd0);
        chk("hold_ce_pulses", ceCnt, 32'd0);

        // Address switches during READ: 0x10 fill completes, then 0x20 misses.
        step(1'b1, 32'h10);
        stallCnt = 1;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 32'h20);
            if (sStall) stallCnt++;
        end
        chk("switch_stall_total", stallCnt, 32'd8);

        // Disabled fetch: no activity.
        for (int i = 0; i < 3; i++) step(1'b0, 32'h40);

        // Low address bits take part in the compare.
        step(1'b1, 32'h21);

        // Randomised traffic.
        prevA = 32'h0;
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                a = prevA;
            end else begin
                a = 32'($urandom_range(0, 7)) << 2;
                if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
            end
            prevA = a;
            step(en, a);
        end

        // Reset in the middle of a READ.
        while (mBusy > 0) step(1'b0, 32'h0);
        step(1'b1, 32'h0);
        step(1'b1, 32'h0);
        if (mValid) savedAddr = mAddr; else savedAddr = 32'h0;
        a = (savedAddr == 32'h80) ? 32'h84 : 32'h80;
        step(1'b1, a);
        #2 rst = 1'b1;
        #1;
        chk("rst_read_ce_n", {31'd0, ceN}, 32'd1);
        chk("rst_read_stall", {31'd0, fetch.stall_o}, 32'd0);
        chk("rst_read_data", fetch.instData_o, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        modelReset();
        step(1'b0, 32'h0);
        // The address that would have hit before reset must now miss.
        step(1'b1, savedAddr);
        chk("rst_clears_buf", {31'd0, sStall}, 32'd1);
        for (int i = 0; i < 6; i++) step(1'b1, savedAddr);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/inst_sram_ctrl.md
Name: inst_sram_ctrl

Overview:
- Instruction-side memory controller directly upstream of the cpu core.
- Serves the core's fetch port (instAddr_o / instEnable_o in, instData_i out) from an external multi-cycle asynchronous SRAM.
- Holds a one-entry fetch buffer so that repeated fetches of the same address complete with no wait.
- Drives stall_o, which the team wires into pc_reg and if_id to freeze PC and IF/ID on a miss.

Parameters:
- ADDR_W, 32, width of fetch address (matches InstAddrBus).
- DATA_W, 32, width of instruction word (matches InstBus).
- SRAM_AW, 18, SRAM word-address width.
- WAIT_CYCLES, 2, SRAM read wait states (valid range 0..15).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- instAddr_i  input  ADDR_W  byte fetch address from the core.
- instEnable_i  input  1  fetch request from the core.
- instData_o  output  DATA_W  instruction to the core.
- stall_o  output  1  core must hold PC and IF/ID this cycle.
- sram_addr_o  output  SRAM_AW  SRAM word address, equal to the latched address bits [SRAM_AW+1:2].
- sram_rdata_i  input  DATA_W  SRAM read data.
- sram_ce_n_o  output  1  SRAM chip enable, active-low.
- sram_oe_n_o  output  1  SRAM output enable, active-low.
- sram_we_n_o  output  1  SRAM write enable, active-low; held at 1 permanently.

Behaviour:
- State: FSM with states IDLE and READ; req_addr register; 4-bit wait counter cnt; buffer {buf_valid, buf_addr, buf_data}.
- Reset (asynchronous, any state):
  - state=IDLE, buf_valid=0, cnt=0, req_addr=0.
  - sram_ce_n_o=1, sram_oe_n_o=1, sram_addr_o=0.
  - instData_o=0, stall_o=0.
- Hit: hit = buf_valid & (instAddr_i == buf_addr). The low two address bits take part in the compare.
- IDLE, instEnable_i=0: stall_o=0, instData_o=0, no SRAM access.
- IDLE, instEnable_i=1 and hit: stall_o=0, instData_o=buf_data (combinational), no SRAM access.
- IDLE, instEnable_i=1 and miss:
  - stall_o=1, instData_o=0.
  - On the clock edge: req_addr<=instAddr_i, cnt<=WAIT_CYCLES, ce_n/oe_n<=0, state<=READ.
- READ:
  - stall_o=1, instData_o=0; SRAM strobes stay low; sram_addr_o is held from req_addr.
  - cnt decrements each cycle.
  - When cnt==0: on that edge buf_data<=sram_rdata_i, buf_addr<=req_addr, buf_valid<=1, ce_n/oe_n<=1, state<=IDLE.
- Miss latency: the first request cycle plus WAIT_CYCLES+1 READ cycles, i.e. stall_o is high for WAIT_CYCLES+2 consecutive cycles. Data is presented on the next cycle with stall_o=0.
- Address change during READ: ignored. The fill completes for req_addr. Back in IDLE the new address is compared again and misses if different.
- instEnable_i dropping during READ: the fill still completes; stall_o is deasserted once back in IDLE.
- Simultaneous fill completion and new request: the request is evaluated in the following IDLE cycle against the updated buffer.
- No writes: the block never drives the SRAM write strobe (sram_we_n_o=1).

Optional Feature:
- Macro: INST_PREFETCH_EN.
- Enabled:
  - Adds a second buffer entry {pf_valid, pf_addr, pf_data}.
  - After each demand fill, in the next IDLE cycle with no demand miss, an SRAM read of buf_addr+4 starts. It uses the same READ timing with stall_o=0 while prefetching.
  - Hit on either entry serves with no stall.
  - Demand miss to pf address during a prefetch: stall_o=1 until the prefetch completes; the prefetched word is then served.
  - Demand miss to any other address: the prefetch aborts with no capture and cnt reloads for the demand read.
  - Reset clears pf_valid.
- Disabled: single entry, no speculative SRAM reads.

Test Plan:
- Reset then idle -> all outputs 0, strobes 1; assert rst during READ -> next cycle state IDLE, ce_n=1, stall_o=0, buf_valid=0.
- WAIT_CYCLES=2, SRAM word at 0x0 = 0x1234ABCD, fetch 0x00000000 -> stall_o high exactly 4 cycles, then instData_o=0x1234ABCD with stall_o=0; sram_addr_o=0 during the access.
- Hold instAddr_i=0x00000000 for 5 further cycles after the fill -> stall_o=0 throughout, no further ce_n=0 pulse.
- During READ of 0x10, change instAddr_i to 0x20 -> fill completes for 0x10 (buf_addr=0x10), then a second 4-cycle stall for 0x20.
- instEnable_i=0 with instAddr_i=0x40 -> no SRAM activity, instData_o=0, stall_o=0.
- INST_PREFETCH_EN, sequential fetch 0x0, 0x4, 0x8 with WAIT_CYCLES=0 -> miss stall only on 0x0; 0x4 served with zero stall; 0x8 incurs at most a partial stall for the in-flight prefetch.
